// File: rtl/key_seq_pkg.sv
// Shared definitions for the key interrupt sequencer: FSM state encoding and
// the register map of the key PIO it services.
// Timestamp option: KEY_SEQ_TIMESTAMP_EN (no package content depends on it).
package key_seq_pkg;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        RD_CAP,
        CAP_WAIT,
        CLR,
        RD_DAT,
        DAT_WAIT,
        PUSH,
        CFG
    } key_seq_state_e;

    // Key PIO register map
    localparam logic [1:0] KEY_ADDR_DATA = 2'd0;
    localparam logic [1:0] KEY_ADDR_MASK = 2'd2;
    localparam logic [1:0] KEY_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/key_seq_fifo.sv
// Purpose: generic first-word-fall-through FIFO holding captured key events.
// Latency: a pushed word is visible at out_dat the cycle after the push.
// Backpressure: in_rdy drops when full unless the consumer pops in the same cycle.
//
// Ports: clk, reset (sync, active-high); in_vld/in_rdy/in_dat write side;
//        out_vld/out_rdy/out_dat read side (out_vld = not empty).
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module key_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    // A pop in the same cycle frees the slot the push lands in.
    assign in_rdy  = (count != FULL_CNT) || out_rdy;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

endmodule

// File: rtl/key_irq_sequencer.sv
// Purpose: services the key PIO interrupt, reads/clears edges, queues {edges, level} events.
// Latency: 7 cycles minimum from key_irq in IDLE to the event at the FIFO output.
// Backpressure: evt_valid/evt_ready stream; a full queue drops the event and sets overflow.
//
// Ports: clk, reset (sync, active-high); avm_* master to the key PIO (read latency 1);
//        key_irq; cfg_mask_wr/cfg_mask mask rewrite request; ovf_clr; evt_valid/evt_ready/
//        evt_edges/evt_level event stream; overflow, busy status.
// Option: define KEY_SEQ_TIMESTAMP_EN to add a 16-bit free-running counter and the
//         evt_time output (counter value captured in CAP_WAIT, stored per event).
module key_irq_sequencer
    import key_seq_pkg::*;
#(
    parameter int               KEY_W      = 4,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [KEY_W-1:0] MASK_INIT  = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             key_irq,
    input  logic             cfg_mask_wr,
    input  logic [KEY_W-1:0] cfg_mask,
    input  logic             ovf_clr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [KEY_W-1:0] evt_edges,
    output logic [KEY_W-1:0] evt_level,
`ifdef KEY_SEQ_TIMESTAMP_EN
    output logic [15:0]      evt_time,
`endif
    output logic             overflow,
    output logic             busy
);

`ifdef KEY_SEQ_TIMESTAMP_EN
    localparam int ENT_W = 2 * KEY_W + 16;
`else
    localparam int ENT_W = 2 * KEY_W;
`endif

    key_seq_state_e   state;
    key_seq_state_e   state_nxt;
    logic             cfg_pend;
    logic [KEY_W-1:0] cfg_val;
    logic [KEY_W-1:0] edges_q;
    logic [KEY_W-1:0] level_q;
    logic [KEY_W-1:0] rd_keys;
    logic             cs_c;
    logic             wr_n_c;
    logic [1:0]       addr_c;
    logic [31:0]      wdata_c;
    logic             push_c;
    logic             fifo_in_rdy;
    logic [ENT_W-1:0] fifo_in_dat;
    logic [ENT_W-1:0] fifo_out_dat;
    logic             ovf_set;
    logic             unused_rd_hi;

    assign rd_keys      = avm_readdata[KEY_W-1:0];
    assign unused_rd_hi = ^avm_readdata[31:KEY_W];

    // A request arriving this very cycle already counts as pending, so a
    // cfg pulse coinciding with key_irq is serviced first.
    always_comb begin
        state_nxt = state;
        cs_c      = 1'b0;
        wr_n_c    = 1'b1;
        addr_c    = KEY_ADDR_DATA;
        wdata_c   = '0;
        push_c    = 1'b0;
        case (state)
            INIT: begin
                cs_c             = 1'b1;
                wr_n_c           = 1'b0;
                addr_c           = KEY_ADDR_MASK;
                wdata_c[KEY_W-1:0] = MASK_INIT;
                state_nxt        = IDLE;
            end
            IDLE: begin
                if (cfg_pend || cfg_mask_wr) begin
                    state_nxt = CFG;
                end else if (key_irq) begin
                    state_nxt = RD_CAP;
                end
            end
            CFG: begin
                cs_c             = 1'b1;
                wr_n_c           = 1'b0;
                addr_c           = KEY_ADDR_MASK;
                wdata_c[KEY_W-1:0] = cfg_val;
                state_nxt        = IDLE;
            end
            RD_CAP: begin
                cs_c      = 1'b1;
                addr_c    = KEY_ADDR_EDGE;
                state_nxt = CAP_WAIT;
            end
            CAP_WAIT: begin
                // Spurious interrupt: nothing captured, nothing to clear or report.
                state_nxt = (rd_keys == '0) ? IDLE : CLR;
            end
            CLR: begin
                cs_c             = 1'b1;
                wr_n_c           = 1'b0;
                addr_c           = KEY_ADDR_EDGE;
                wdata_c[KEY_W-1:0] = edges_q;
                state_nxt        = RD_DAT;
            end
            RD_DAT: begin
                cs_c      = 1'b1;
                addr_c    = KEY_ADDR_DATA;
                state_nxt = DAT_WAIT;
            end
            DAT_WAIT: begin
                state_nxt = PUSH;
            end
            PUSH: begin
                push_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Bus strobes are forced idle while reset is held, even though the
    // state register already sits in INIT.
    assign avm_chipselect = cs_c && !reset;
    assign avm_write_n    = wr_n_c || reset;
    assign avm_address    = addr_c;
    assign avm_writedata  = wdata_c;
    assign busy           = (state != IDLE);
    assign ovf_set        = push_c && !fifo_in_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            cfg_pend <= 1'b0;
            cfg_val  <= '0;
            edges_q  <= '0;
            level_q  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            // Newest request wins; one landing during CFG stays pending.
            if (cfg_mask_wr) begin
                cfg_pend <= 1'b1;
                cfg_val  <= cfg_mask;
            end else if (state == CFG) begin
                cfg_pend <= 1'b0;
            end
            if (state == CAP_WAIT) begin
                edges_q <= rd_keys;
            end
            if (state == DAT_WAIT) begin
                level_q <= rd_keys;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef KEY_SEQ_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] ts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (state == CAP_WAIT) begin
                ts_q <= ts_cnt;
            end
        end
    end

    assign fifo_in_dat = {edges_q, level_q, ts_q};
    assign evt_edges   = fifo_out_dat[ENT_W-1 -: KEY_W];
    assign evt_level   = fifo_out_dat[16 +: KEY_W];
    assign evt_time    = fifo_out_dat[15:0];
`else
    assign fifo_in_dat = {edges_q, level_q};
    assign evt_edges   = fifo_out_dat[ENT_W-1 -: KEY_W];
    assign evt_level   = fifo_out_dat[KEY_W-1:0];
`endif

    key_seq_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (push_c),
        .in_rdy  (fifo_in_rdy),
        .in_dat  (fifo_in_dat),
        .out_vld (evt_valid),
        .out_rdy (evt_ready),
        .out_dat (fifo_out_dat)
    );

endmodule

// File: tb/tb_key_irq_sequencer.sv
// Bench for key_irq_sequencer: behavioural key PIO (1-cycle read latency, write log),
// transaction-level event queue / overflow model, directed steps then random services.
module tb_key_irq_sequencer;

    localparam int KEY_W = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  e;
        logic [3:0]  l;
        logic [15:0] t;
    } ev_t;

    logic        clk;
    logic        reset;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        key_irq;
    logic        cfg_mask_wr;
    logic [3:0]  cfg_mask;
    logic        ovf_clr;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_edges;
    logic [3:0]  evt_level;
`ifdef KEY_SEQ_TIMESTAMP_EN
    logic [15:0] evt_time;
    logic [15:0] tb_cnt;
`endif
    logic        overflow;
    logic        busy;

    logic [3:0]  pio_edge;
    logic [3:0]  pio_data;
    logic [33:0] wr_log[$];
    ev_t         q[$];
    logic        ovf_exp;
    int          total = 0;
    int          bad = 0;

    key_irq_sequencer #(
        .KEY_W      (KEY_W),
        .FIFO_DEPTH (DEPTH),
        .MASK_INIT  (4'hF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .key_irq        (key_irq),
        .cfg_mask_wr    (cfg_mask_wr),
        .cfg_mask       (cfg_mask),
        .ovf_clr        (ovf_clr),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_edges      (evt_edges),
        .evt_level      (evt_level),
`ifdef KEY_SEQ_TIMESTAMP_EN
        .evt_time       (evt_time),
`endif
        .overflow       (overflow),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key PIO: read data appears the cycle after the read is presented; junk otherwise.
    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n) begin
            case (avm_address)
                2'd0:    avm_readdata <= {28'hC0FFEE0, pio_data};
                2'd3:    avm_readdata <= {28'hBEEFCA0, pio_edge};
                default: avm_readdata <= 32'h0;
            endcase
        end else begin
            avm_readdata <= 32'hA5A5_A5A5;
        end
        if (avm_chipselect && !avm_write_n) begin
            wr_log.push_back({avm_address, avm_writedata});
        end
    end

`ifdef KEY_SEQ_TIMESTAMP_EN
    always @(posedge clk) begin
        if (reset) tb_cnt <= 16'd0;
        else       tb_cnt <= tb_cnt + 16'd1;
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input int n);
        ev_t ev;
        for (int i = 0; i < n; i++) begin
            ev = q.pop_front();
            chk("drain_vld", {31'd0, evt_valid}, 1);
            chk("drain_edges", {28'd0, evt_edges}, {28'd0, ev.e});
            chk("drain_level", {28'd0, evt_level}, {28'd0, ev.l});
`ifdef KEY_SEQ_TIMESTAMP_EN
            chk("drain_time", {16'd0, evt_time}, {16'd0, ev.t});
`endif
            evt_ready = 1'b1;
            @(posedge clk); #1;
        end
        evt_ready = 1'b0;
    endtask

    task automatic pulse_ovf_clr();
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        ovf_exp = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 0);
    endtask

    // One interrupt service starting from IDLE; optional pop / ovf_clr in the PUSH cycle.
    task automatic service(input logic [3:0] e, input logic [3:0] l,
                           input bit rdy6, input bit clr6, output int t_valid);
        int  base;
        int  t_idle;
        bit  set;
        ev_t ev;
        base    = wr_log.size();
        t_valid = -1;
        t_idle  = -1;
        set     = 1'b0;
        ev.e    = e;
        ev.l    = l;
        ev.t    = 16'd0;
        pio_edge = e;
        pio_data = l;
        key_irq  = 1'b1;
        for (int k = 1; k <= 20 && t_idle < 0; k++) begin
            @(posedge clk); #1;
            key_irq   = 1'b0;
            evt_ready = 1'b0;
            ovf_clr   = 1'b0;
`ifdef KEY_SEQ_TIMESTAMP_EN
            if (k == 2) ev.t = tb_cnt;
`endif
            if (k == 6) begin
                ovf_clr = clr6;
                if (rdy6 && q.size() > 0) begin
                    chk("sp_pop_edges", {28'd0, evt_edges}, {28'd0, q[0].e});
                    chk("sp_pop_level", {28'd0, evt_level}, {28'd0, q[0].l});
                    void'(q.pop_front());
                    evt_ready = 1'b1;
                end
            end
            if (evt_valid && t_valid < 0) t_valid = k;
            if (!busy) t_idle = k;
        end
        chk("svc_idle", t_idle, (e != 4'd0) ? 7 : 3);
        if (e != 4'd0) begin
            chk("svc_wrcnt", wr_log.size(), base + 1);
            if (wr_log.size() > base) begin
                chk("clr_addr", {30'd0, wr_log[base][33:32]}, 3);
                chk("clr_data", wr_log[base][31:0], {28'd0, e});
            end
            if (q.size() < DEPTH) q.push_back(ev);
            else                  set = 1'b1;
        end else begin
            chk("svc_nowr", wr_log.size(), base);
        end
        if (set)       ovf_exp = 1'b1;
        else if (clr6) ovf_exp = 1'b0;
        chk("svc_ovf", {31'd0, overflow}, {31'd0, ovf_exp});
        chk("svc_vld", {31'd0, evt_valid}, {31'd0, q.size() != 0});
    endtask

    initial begin
        int         tv;
        int         n;
        int         base;
        int         guard;
        logic [3:0] re;
        logic [3:0] rl;

        reset       = 1'b1;
        key_irq     = 1'b0;
        cfg_mask_wr = 1'b0;
        cfg_mask    = 4'h0;
        ovf_clr     = 1'b0;
        evt_ready   = 1'b0;
        pio_edge    = 4'h0;
        pio_data    = 4'h0;
        ovf_exp     = 1'b0;
        guard       = 0;

        // Reset state and the INIT mask write
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", {31'd0, avm_chipselect}, 0);
        chk("rst_vld", {31'd0, evt_valid}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        reset = 1'b0;
        #1;
        base = wr_log.size();
        chk("init_cs", {31'd0, avm_chipselect}, 1);
        chk("init_wrn", {31'd0, avm_write_n}, 0);
        chk("init_addr", {30'd0, avm_address}, 2);
        chk("init_wdata", avm_writedata, 32'hF);
        chk("init_busy", {31'd0, busy}, 1);
        @(posedge clk); #1;
        chk("idle_busy", {31'd0, busy}, 0);
        chk("init_logged", wr_log.size(), base + 1);
        @(posedge clk); #1;
        chk("idle_stays", {31'd0, busy}, 0);

        // Basic service: edges 0x4, level 0xB, event visible 7 cycles after irq
        service(4'h4, 4'hB, 1'b0, 1'b0, tv);
        chk("svc_latency", tv, 7);
        drain(1);
        chk("empty_after", {31'd0, evt_valid}, 0);

        // Spurious irq: no clear, no event, idle after 3 cycles
        service(4'h0, 4'h5, 1'b0, 1'b0, tv);
        chk("spur_noevt", tv, -1);

        // cfg pulse together with key_irq: mask write first, then the irq sequence
        base        = wr_log.size();
        pio_edge    = 4'h2;
        pio_data    = 4'h6;
        cfg_mask    = 4'h3;
        cfg_mask_wr = 1'b1;
        key_irq     = 1'b1;
        @(posedge clk); #1;
        cfg_mask_wr = 1'b0;
        chk("cfg_cs", {31'd0, avm_chipselect}, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        key_irq = 1'b0;
        for (int k = 0; k < 12 && busy; k++) begin
            @(posedge clk); #1;
        end
        chk("cfg_done", {31'd0, busy}, 0);
        chk("cfg_wrcnt", wr_log.size(), base + 2);
        if (wr_log.size() >= base + 2) begin
            chk("cfg_first", {30'd0, wr_log[base][33:32]}, 2);
            chk("cfg_val", wr_log[base][31:0], 32'h3);
            chk("cfg_then_clr", wr_log[base + 1], {2'd3, 32'h2});
        end
        q.push_back('{e: 4'h2, l: 4'h6, t: 16'd0});
`ifdef KEY_SEQ_TIMESTAMP_EN
        q[0].t = evt_time;
`endif
        drain(1);

        // Overflow: five services into a depth-4 queue with no consumer
        for (int i = 0; i < 5; i++) begin
            service(4'(i + 1), 4'(15 - i), 1'b0, 1'b0, tv);
        end
        pulse_ovf_clr();
        drain(4);
        chk("ovf_drained", {31'd0, evt_valid}, 0);

        // Full queue: pop during PUSH lets the push in; set beats a same-cycle clear
        for (int i = 0; i < 4; i++) begin
            service(4'(8 - i), 4'(i), 1'b0, 1'b0, tv);
        end
        service(4'h9, 4'hC, 1'b1, 1'b0, tv);
        service(4'hA, 4'hD, 1'b0, 1'b1, tv);
        drain(4);
        pulse_ovf_clr();

        // Reset during DAT_WAIT: no partial push, INIT re-runs
        service(4'h1, 4'h2, 1'b0, 1'b0, tv);
        pio_edge = 4'h8;
        pio_data = 4'h7;
        key_irq  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            key_irq = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("mid_rst_cs", {31'd0, avm_chipselect}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        q.delete();
        ovf_exp = 1'b0;
        chk("mid_vld", {31'd0, evt_valid}, 0);
        chk("mid_init_cs", {31'd0, avm_chipselect}, 1);
        chk("mid_init_wrn", {31'd0, avm_write_n}, 0);
        chk("mid_init_addr", {30'd0, avm_address}, 2);
        chk("mid_init_wdata", avm_writedata, 32'hF);
        @(posedge clk); #1;
        chk("mid_idle", {31'd0, busy}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_nopush", {31'd0, evt_valid}, 0);

        // Random services, partial drains and overflow clears against the model
        for (int it = 0; it < 40; it++) begin
            re = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            rl = 4'($urandom);
            service(re, rl, 1'b0, 1'b0, tv);
            n = $urandom_range(0, 3);
            if (n > q.size()) n = q.size();
            drain(n);
            if ($urandom_range(0, 3) == 0) pulse_ovf_clr();
        end
        drain(q.size());
        chk("rand_empty", {31'd0, evt_valid}, 0);

`ifdef KEY_SEQ_TIMESTAMP_EN
        // Timestamps captured on both sides of the counter wrap
        while (tb_cnt != 16'hFFFD && guard < 70000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("wrap_reach", {16'd0, tb_cnt}, 32'hFFFD);
        service(4'h1, 4'h9, 1'b0, 1'b0, tv);
        chk("wrap_t0", {16'd0, evt_time}, 32'hFFFF);
        service(4'h2, 4'hA, 1'b0, 1'b0, tv);
        drain(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_irq_sequencer.md
KEY_IRQ_SEQUENCER -- requirements
Module: key_irq_sequencer

Interface
REQ-001 The block SHALL have parameter KEY_W, default 4, which sets the key count.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, a power of two >=2, which sets the event queue depth.
REQ-003 The block SHALL have parameter MASK_INIT, default 4'hF, the irq_mask value written after reset.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock.
REQ-005 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-006 Ports avm_address (out, 2), avm_chipselect (out, 1), avm_write_n (out, 1), avm_writedata (out, 32) and avm_readdata (in, 32) SHALL form the master port to the key PIO.
REQ-007 Port key_irq SHALL be an input, 1 bit: the PIO interrupt.
REQ-008 Ports cfg_mask_wr (in, 1) and cfg_mask (in, KEY_W) SHALL form a one-cycle request to rewrite the mask.
REQ-009 Port ovf_clr SHALL be an input, 1 bit: it clears the overflow flag.
REQ-010 Ports evt_valid (out, 1), evt_ready (in, 1), evt_edges (out, KEY_W) and evt_level (out, KEY_W) SHALL form the event stream.
REQ-011 Outputs overflow (1) and busy (1) SHALL report status.

Function
REQ-012 PIO read latency SHALL be exactly 1: avm_readdata sampled in the cycle after the address is presented.
REQ-013 The FSM states SHALL be INIT, IDLE, RD_CAP, CAP_WAIT, CLR, RD_DAT, DAT_WAIT, PUSH and CFG.
REQ-014 INIT SHALL write MASK_INIT to address 2 in one cycle, then go to IDLE.
REQ-015 In IDLE, pending cfg SHALL take priority over key_irq: CFG writes the latched cfg_mask to address 2, then returns to IDLE.
REQ-016 A cfg_mask_wr pulse SHALL be latched whenever it arrives; a later pulse before service SHALL overwrite the earlier one.
REQ-017 On key_irq=1 in IDLE, the FSM SHALL run RD_CAP (read address 3), CAP_WAIT (capture edges), CLR (write the captured edges to address 3), RD_DAT (read address 0), DAT_WAIT (capture level), PUSH, then IDLE.
REQ-018 If the captured edges are zero, the FSM SHALL go CAP_WAIT -> IDLE, with no clear and no push.
REQ-019 Edges arriving between CAP_WAIT and CLR SHALL be lost; the PIO clear is global, and this loss is accepted.
REQ-020 avm_chipselect SHALL be 1 only in INIT, CFG, RD_CAP, CLR and RD_DAT; avm_write_n SHALL be 0 only in INIT, CFG and CLR; writedata upper bits SHALL be zero.
REQ-021 PUSH SHALL enqueue {edges, level} when the FIFO is not full; when full, it SHALL drop the event and set overflow.
REQ-022 overflow SHALL be sticky; ovf_clr clears it; a set in the same cycle as a clear SHALL win.
REQ-023 The FIFO SHALL be first-word-fall-through: evt_valid = not empty, and a pop occurs on evt_valid & evt_ready.
REQ-024 A simultaneous push and pop SHALL be legal when full, and the push SHALL then succeed.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Minimum service time from key_irq to the event at the FIFO output SHALL be 7 cycles.

Reset
REQ-027 Reset SHALL set the FSM to INIT, empty the FIFO, and set overflow=0, the cfg latch=0, evt_valid=0 and avm_chipselect=0.
REQ-028 Reset asserted mid-sequence SHALL abandon the transaction, with no partial push; INIT SHALL re-run.

Configuration
REQ-029 With KEY_SEQ_TIMESTAMP_EN defined, the block SHALL add a free-running 16-bit counter (reset 0, wraps 16'hFFFF->0) and an output evt_time (16) stored per entry, equal to the counter value in CAP_WAIT.
REQ-030 Without KEY_SEQ_TIMESTAMP_EN, the evt_time port, counter and storage SHALL be absent.

Structure
REQ-031 Package key_seq_pkg SHALL hold the state enum and the address constants KEY_ADDR_DATA=0, KEY_ADDR_MASK=2 and KEY_ADDR_EDGE=3.
REQ-032 The FIFO SHALL be sub-module key_seq_fifo, parameterised for width and depth.

Verification
REQ-033 Release reset -> next cycle shows cs=1, wr_n=0, addr=2, wdata=0xF; the following cycle busy=0.
REQ-034 key_irq=1, edge read returns 0x4, data read returns 0xB -> write of 0x4 to addr 3 in CLR; event {edges=0x4, level=0xB} becomes valid 7 cycles after irq.
REQ-035 Edge read returns 0 -> no address-3 write, no event, IDLE after 3 cycles.
REQ-036 evt_ready=0 and 5 irq services at FIFO_DEPTH=4 -> 4 events held, overflow=1; ovf_clr -> overflow=0; drain in order.
REQ-037 cfg_mask_wr with 0x3 pulsed together with key_irq in IDLE -> CFG write of 0x3 to addr 2 first, then the irq sequence.
REQ-038 reset during DAT_WAIT -> FIFO empty and INIT write repeated; with KEY_SEQ_TIMESTAMP_EN, evt_time equals the counter at CAP_WAIT, including across the 0xFFFF wrap.
